// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: per-window spike count and membrane peak, inter-spike
// interval tracking, and a serial readout of the latched results.
module spike_rate_monitor #(
   parameter int WINDOW_LOG2 = 8,
   parameter int ISI_W       = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             spike_in,
   input  logic [7:0]       membrane_in,
   input  logic             rd_req,
   output logic [7:0]       rate_out,
   output logic [7:0]       peak_out,
   output logic [ISI_W-1:0] isi_out,
   output logic             isi_valid,
   output logic             window_done,
   output logic             ser_data,
   output logic             ser_valid,
   output logic             ser_last
);

   localparam int SER_W = 16 + ISI_W;
   localparam int CNT_W = $clog2(SER_W);
   localparam logic [WINDOW_LOG2-1:0] WIN_MAX  = '1;
   localparam logic [ISI_W-1:0]       ISI_MAX  = '1;
   localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(SER_W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   logic                   prev_spike;
   logic [WINDOW_LOG2-1:0] win_cnt;
   logic [7:0]             spike_cnt;
   logic [7:0]             peak;
   logic [ISI_W-1:0]       isi_cnt;
   logic                   seen_first;

   logic                   spike_event;
   logic                   terminal;
   logic [7:0]             spike_next;
   logic [7:0]             peak_next;
   logic [ISI_W-1:0]       isi_inc;

   state_t                 state;
   state_t                 state_next;
   logic [SER_W-1:0]       shift_reg;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   load;

   // The terminal cycle's own spike and membrane sample are folded into the
   // latched results, so next-values are computed combinationally.
   always_comb begin
      spike_event = enable && spike_in && !prev_spike;
      terminal    = enable && (win_cnt == WIN_MAX);
      spike_next  = (spike_event && (spike_cnt != 8'hFF)) ? spike_cnt + 8'd1 : spike_cnt;
      peak_next   = (membrane_in > peak) ? membrane_in : peak;
      isi_inc     = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_spike  <= 1'b0;
         win_cnt     <= '0;
         spike_cnt   <= 8'd0;
         peak        <= 8'd0;
         isi_cnt     <= '0;
         seen_first  <= 1'b0;
         rate_out    <= 8'd0;
         peak_out    <= 8'd0;
         isi_out     <= '0;
         isi_valid   <= 1'b0;
         window_done <= 1'b0;
      end else begin
         window_done <= terminal;
         if (enable) begin
            prev_spike <= spike_in;
            win_cnt    <= win_cnt + 1'b1;
            if (terminal) begin
               rate_out  <= spike_next;
               peak_out  <= peak_next;
               spike_cnt <= 8'd0;
               peak      <= 8'd0;
            end else begin
               spike_cnt <= spike_next;
               peak      <= peak_next;
            end
            // The first edge only arms the interval; isi_out stays 0 until a second edge.
            if (spike_event) begin
               isi_cnt    <= '0;
               seen_first <= 1'b1;
               if (seen_first) begin
                  isi_out   <= isi_inc;
                  isi_valid <= 1'b1;
               end
            end else begin
               isi_cnt <= isi_inc;
            end
         end
      end
   end

   // Readout handshake: ser_valid high marks each cycle ser_data holds a
   // snapshot bit (MSB first); ser_last accompanies only the final bit and
   // rd_req is accepted solely in IDLE.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      ser_valid  = 1'b0;
      ser_data   = 1'b0;
      ser_last   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_data  = shift_reg[SER_W-1];
            ser_last  = (bit_cnt == LAST_BIT);
            if (bit_cnt == LAST_BIT) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The snapshot reads the output registers before any same-cycle window latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            shift_reg <= {rate_out, peak_out, isi_out};
            bit_cnt   <= '0;
         end else if (state == SHIFT) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor (WINDOW_LOG2=4, ISI_W=12) with
// hand-computed expectations checked by immediate assertions.
module tb_spike_rate_monitor;

   localparam int WL = 4;
   localparam int IW = 12;
   localparam int SW = 16 + IW;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          spike_in;
   logic [7:0]    membrane_in;
   logic          rd_req;
   logic [7:0]    rate_out;
   logic [7:0]    peak_out;
   logic [IW-1:0] isi_out;
   logic          isi_valid;
   logic          window_done;
   logic          ser_data;
   logic          ser_valid;
   logic          ser_last;

   int checks   = 0;
   int errors   = 0;
   int wd_count = 0;

   always #5 clk = ~clk;

   spike_rate_monitor #(.WINDOW_LOG2(WL), .ISI_W(IW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .spike_in    (spike_in),
      .membrane_in (membrane_in),
      .rd_req      (rd_req),
      .rate_out    (rate_out),
      .peak_out    (peak_out),
      .isi_out     (isi_out),
      .isi_valid   (isi_valid),
      .window_done (window_done),
      .ser_data    (ser_data),
      .ser_valid   (ser_valid),
      .ser_last    (ser_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step(input logic en, input logic sp, input logic [7:0] mem, input logic rd);
      enable      = en;
      spike_in    = sp;
      membrane_in = mem;
      rd_req      = rd;
      @(posedge clk);
      #1;
      if (window_done) wd_count++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rate"}, rate_out, 0);
      check({tag, " peak"}, peak_out, 0);
      check({tag, " isi"}, isi_out, 0);
      check({tag, " isi_valid"}, isi_valid, 0);
      check({tag, " window_done"}, window_done, 0);
      check({tag, " ser_valid"}, ser_valid, 0);
      check({tag, " ser_data"}, ser_data, 0);
      check({tag, " ser_last"}, ser_last, 0);
   endtask

   // Called right after the rd_req cycle; a stray rd_req is injected at bit 3.
   task automatic readout(input string tag, input logic [SW-1:0] exp_bits,
                          input int mid_k, input logic [7:0] mid_rate);
      for (int k = 0; k < SW; k++) begin
         check({tag, " valid"}, ser_valid, 1);
         check({tag, " data"}, ser_data, exp_bits[SW-1-k]);
         check({tag, " last"}, ser_last, (k == SW - 1));
         if (k == mid_k) check({tag, " rate mid-shift"}, rate_out, mid_rate);
         step(1'b1, 1'b0, 8'h00, (k == 3));
      end
      check({tag, " back to idle"}, ser_valid, 0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; spike_in = 1'b0; membrane_in = 8'h00; rd_req = 1'b0;
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'hFF, 1'b1);
      check_all_zero("reset");
      reset = 1'b0;

      // Window 1 (e=0..15): edges every 4 cycles
      wd_count = 0;
      for (int e = 0; e < 16; e++) begin
         step(1'b1, (e % 4 == 0), 8'h00, 1'b0);
         if (e == 0) check("isi_valid after first edge", isi_valid, 0);
         if (e == 4) begin
            check("isi_valid after second edge", isi_valid, 1);
            check("isi 4", isi_out, 4);
         end
         if (e == 14) check("window_done early", window_done, 0);
      end
      check("w1 rate", rate_out, 4);
      check("w1 peak", peak_out, 0);
      check("w1 window_done", window_done, 1);

      // Window 2 (e=16..31): spike held high, membrane ramp to 200
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, (i == 15) ? 8'd200 : 8'(i * 13), 1'b0);
         if (i == 0) begin
            check("window_done one cycle", window_done, 0);
            check("window_done pulse count", wd_count, 1);
         end
      end
      check("w2 rate held high", rate_out, 1);
      check("w2 peak ramp", peak_out, 200);

      // Window 3 (e=32..47): high 4 more cycles, then edge at e=38
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i < 4) || (i == 6), (i == 8) ? 8'd50 : 8'd30, 1'b0);
         if (i == 6) check("isi 22", isi_out, 22);
      end
      check("w3 rate", rate_out, 1);
      check("w3 peak", peak_out, 50);

      // Window 4 (e=48..63) with 7 disabled cycles after e=51
      step(1'b1, 1'b1, 8'd100, 1'b0);
      check("isi 10", isi_out, 10);
      for (int e = 49; e < 52; e++) step(1'b1, 1'b0, 8'd100, 1'b0);
      for (int d = 0; d < 7; d++) begin
         step(1'b0, 1'b1, 8'hFF, 1'b0);
         check("window_done while disabled", window_done, 0);
      end
      for (int e = 52; e < 64; e++) begin
         step(1'b1, (e == 55), 8'd100, 1'b0);
         if (e == 55) check("isi 7 skips disabled", isi_out, 7);
         if (e == 62) check("window_done delayed", window_done, 0);
      end
      check("w4 window_done", window_done, 1);
      check("w4 rate", rate_out, 2);
      check("w4 peak", peak_out, 100);

      // Window 5 (e=64..79): five edges, peak 0xA0
      for (int e = 64; e < 80; e++)
         step(1'b1, (e <= 72) && (e % 2 == 0), (e == 70) ? 8'hA0 : 8'h10, 1'b0);
      check("w5 rate", rate_out, 5);
      check("w5 peak", peak_out, 8'hA0);

      // Window 6: edge at e=82 gives isi 10, readout at e=83 spans the e=95 latch
      for (int e = 80; e < 83; e++) step(1'b1, (e == 82), 8'h00, 1'b0);
      check("isi 0x00A", isi_out, 12'h00A);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      readout("rd1", 28'h05A000A, 12, 8'd1);

      // Window 8 (e=112..127): rd_req on the terminal cycle sees old values
      for (int e = 112; e < 127; e++)
         step(1'b1, (e == 112) || (e == 114) || (e == 116), 8'h33, 1'b0);
      step(1'b1, 1'b0, 8'h33, 1'b1);
      check("w8 window_done", window_done, 1);
      check("w8 rate", rate_out, 3);
      check("w8 peak", peak_out, 8'h33);
      readout("rd2", 28'h0000002, -1, 8'd0);

      // ISI saturation after a long silence
      for (int c = 0; c < 5000; c++) step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'h00, 1'b0);
      check("isi saturated", isi_out, 12'hFFF);
      check("isi_valid held", isi_valid, 1);

      // Reset in the middle of a readout
      step(1'b1, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("shifting before reset", ser_valid, 1);
      reset = 1'b1;
      step(1'b1, 1'b1, 8'hFF, 1'b1);
      check_all_zero("mid-shift reset");
      step(1'b1, 1'b1, 8'hFF, 1'b1);
      check("reset dominates rd_req", ser_valid, 0);
      reset = 1'b0;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("idle after reset", ser_valid, 0);
      check("rate after reset", rate_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_rate_monitor.md
SPIKE_RATE_MONITOR -- requirements
Module: spike_rate_monitor

Interface
REQ-001 Parameter WINDOW_LOG2, default 8: observation window length is 2^WINDOW_LOG2 enabled cycles.
REQ-002 Parameter ISI_W, default 12: inter-spike-interval counter width; saturates at 2^ISI_W-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 enable  input  1  advance enable; when low, all counters, trackers and the edge detector hold.
REQ-006 spike_in  input  1  neuron spike level from the neuron core spike output.
REQ-007 membrane_in  input  8  unsigned membrane value from the neuron core membrane output.
REQ-008 rd_req  input  1  single-cycle request to start a serial readout of latched results.
REQ-009 rate_out  output  8  spike count of last completed window, saturated at 255.
REQ-010 peak_out  output  8  maximum membrane_in sampled during last completed window.
REQ-011 isi_out  output  ISI_W  enabled cycles between the two most recent spike edges.
REQ-012 isi_valid  output  1  high once two spike edges have occurred since reset.
REQ-013 window_done  output  1  one-cycle pulse when a window closes and results latch.
REQ-014 ser_data  output  1  serial readout bit, MSB first.
REQ-015 ser_valid  output  1  high while ser_data carries a valid bit.
REQ-016 ser_last  output  1  high with the final serial bit only.

Function
REQ-017 Spike edge: spike_in sampled when enable=1; rising edge (prev 0, now 1) is one spike event; held-high spike_in counts once.
REQ-018 Window counter: increments each enabled cycle, 0 to 2^WINDOW_LOG2-1, wraps to 0.
REQ-019 Spike counter: increments on each spike event, saturates at 255, never wraps.
REQ-020 Peak tracker: each enabled cycle, peak := max(peak, membrane_in), unsigned compare.
REQ-021 Terminal window cycle (count = 2^WINDOW_LOG2-1, enable=1): rate_out and peak_out latch values including that cycle's spike event and membrane_in; window_done=1 in the following cycle for exactly one cycle.
REQ-022 After the terminal cycle, spike counter and peak tracker restart at 0 for the next window; no cycle lost between windows.
REQ-023 ISI counter: increments each enabled cycle, saturates at 2^ISI_W-1; on spike event isi_out := counter+1 (saturated), counter := 0.
REQ-024 isi_valid: set on second spike event after reset, held until reset; isi_out undefined-free (0) before then.
REQ-025 Readout FSM states: IDLE, SHIFT; runs independently of enable.
REQ-026 IDLE: ser_valid=0; rd_req=1 snapshots {rate_out, peak_out, isi_out} (16+ISI_W bits) into shift register, goes to SHIFT next cycle.
REQ-027 SHIFT: one bit per cycle MSB first, ser_valid=1; ser_last=1 on bit 16+ISI_W-1; returns to IDLE after last bit.
REQ-028 rd_req while in SHIFT is ignored; no queuing.
REQ-029 Window latch during SHIFT updates rate_out/peak_out but does not alter the in-flight snapshot.
REQ-030 rd_req in the same cycle as a window latch snapshots the pre-latch (old) values.

Reset
REQ-031 reset=1: all outputs 0, all counters, trackers, edge register, snapshot 0, FSM to IDLE; reset dominates enable and rd_req.
REQ-032 reset mid-SHIFT aborts readout; ser_valid=0 in the cycle after reset asserts.

Verification
REQ-033 WINDOW_LOG2=4, enable=1, spike_in rising every 4 cycles (high 1 cycle) -> after 16 cycles window_done pulses once, rate_out=4.
REQ-034 spike_in held high 20 cycles -> exactly 1 spike counted; membrane_in ramp 0..200 -> peak_out=200 at window close.
REQ-035 Spike edges 10 enabled cycles apart -> isi_out=10, isi_valid=1 after second edge; no spike for 5000 cycles (ISI_W=12) then edge -> isi_out=4095.
REQ-036 rate_out=0x05, peak_out=0xA0, isi_out=0x00A, rd_req pulse -> 28 ser_valid cycles, bits 0x05A000A MSB first, ser_last on 28th only.
REQ-037 enable low 7 cycles mid-window -> window_done delayed by exactly 7 cycles, counts unchanged; reset asserted mid-SHIFT -> all outputs 0 next cycle.
